// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: 4-bit opcode encodings and the
// control FSM state encodings used by seq_alu.
package alu_pkg;

    localparam int NB_OPCODE = 4;

    typedef enum logic [3:0] {
        OP_ADD   = 4'b0000,
        OP_SUB   = 4'b0001,
        OP_AND   = 4'b0010,
        OP_OR    = 4'b0011,
        OP_XOR   = 4'b0100,
        OP_NOR   = 4'b0101,
        OP_SRL   = 4'b0110,
        OP_SLL   = 4'b0111,
        OP_SRA   = 4'b1000,
        OP_SLA   = 4'b1001,
        OP_SLT   = 4'b1010,
        OP_LUI   = 4'b1011,
        OP_MULT  = 4'b1100,
        OP_MULTU = 4'b1101,
        OP_DIV   = 4'b1110,
        OP_DIVU  = 4'b1111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DIV  = 2'b10,
        ST_DONE = 2'b11
    } state_e;

endpackage

// File: rtl/mdu_core.sv
// Iterative multiply/divide unit: shift-add multiplier and restoring divider,
// one bit per cycle on operand magnitudes, sign-corrected at the end.
// The divider only exists when SEQ_ALU_DIV_EN is defined.
// done/res_hi/res_lo are valid in the last iteration cycle and are captured
// into the output registers of seq_alu on that same edge.
module mdu_core #(
    parameter int NB_DATA = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
`ifdef SEQ_ALU_DIV_EN
    input  logic               is_div,
`endif
    input  logic               is_signed,
    input  logic [NB_DATA-1:0] op_a,
    input  logic [NB_DATA-1:0] op_b,
    output logic               done,
    output logic [NB_DATA-1:0] res_hi,
    output logic [NB_DATA-1:0] res_lo
);

    localparam int NB_CNT = $clog2(NB_DATA);
    localparam logic [NB_CNT-1:0]    LAST_CNT = NB_CNT'(NB_DATA - 1);
    localparam logic [NB_DATA-1:0]   ZERO     = {NB_DATA{1'b0}};
    localparam logic [2*NB_DATA-1:0] ZERO2    = {(2*NB_DATA){1'b0}};

    logic                busy_r;
    logic [NB_CNT-1:0]   cnt_r;
    logic [NB_DATA-1:0]  hi_r;
    logic [NB_DATA-1:0]  lo_r;
    logic [NB_DATA-1:0]  opb_r;
    logic                neg_prod_r;

    logic                neg_a_s;
    logic                neg_b_s;
    logic [NB_DATA-1:0]  mag_a_s;
    logic [NB_DATA-1:0]  mag_b_s;
    logic [NB_DATA:0]    sum_s;
    logic [NB_DATA-1:0]  step_hi_s;
    logic [NB_DATA-1:0]  step_lo_s;
    logic [2*NB_DATA-1:0] prod_s;

`ifdef SEQ_ALU_DIV_EN
    logic                is_div_r;
    logic                neg_rem_r;
    logic                div0_r;
    logic [NB_DATA+1:0]  rem_shift_s;
    logic [NB_DATA+1:0]  diff_s;
`endif

    assign neg_a_s = is_signed & op_a[NB_DATA-1];
    assign neg_b_s = is_signed & op_b[NB_DATA-1];
    assign mag_a_s = neg_a_s ? (ZERO - op_a) : op_a;
    assign mag_b_s = neg_b_s ? (ZERO - op_b) : op_b;
    assign done    = busy_r && (cnt_r == LAST_CNT);

    // One iteration: add-and-shift for multiply, compare-subtract-shift for divide.
    always_comb begin
        sum_s     = {1'b0, hi_r} + (lo_r[0] ? {1'b0, opb_r} : {(NB_DATA+1){1'b0}});
        step_hi_s = sum_s[NB_DATA:1];
        step_lo_s = {sum_s[0], lo_r[NB_DATA-1:1]};
`ifdef SEQ_ALU_DIV_EN
        rem_shift_s = {1'b0, hi_r, lo_r[NB_DATA-1]};
        diff_s      = rem_shift_s - {2'b00, opb_r};
        if (is_div_r) begin
            if (!diff_s[NB_DATA+1]) begin
                step_hi_s = diff_s[NB_DATA-1:0];
                step_lo_s = {lo_r[NB_DATA-2:0], 1'b1};
            end else begin
                step_hi_s = rem_shift_s[NB_DATA-1:0];
                step_lo_s = {lo_r[NB_DATA-2:0], 1'b0};
            end
        end else begin
            step_hi_s = sum_s[NB_DATA:1];
            step_lo_s = {sum_s[0], lo_r[NB_DATA-1:1]};
        end
`endif
    end

    // Sign correction of the final iteration result; divide by zero forces an all-ones quotient.
    always_comb begin
        prod_s = neg_prod_r ? (ZERO2 - {step_hi_s, step_lo_s}) : {step_hi_s, step_lo_s};
        res_hi = prod_s[2*NB_DATA-1:NB_DATA];
        res_lo = prod_s[NB_DATA-1:0];
`ifdef SEQ_ALU_DIV_EN
        if (is_div_r) begin
            res_hi = neg_rem_r ? (ZERO - step_hi_s) : step_hi_s;
            res_lo = div0_r ? {NB_DATA{1'b1}}
                            : (neg_prod_r ? (ZERO - step_lo_s) : step_lo_s);
        end else begin
            res_hi = prod_s[2*NB_DATA-1:NB_DATA];
            res_lo = prod_s[NB_DATA-1:0];
        end
`endif
    end

    // Operand capture on start, then NB_DATA iterations; operands are never re-read.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r     <= 1'b0;
            cnt_r      <= {NB_CNT{1'b0}};
            hi_r       <= ZERO;
            lo_r       <= ZERO;
            opb_r      <= ZERO;
            neg_prod_r <= 1'b0;
`ifdef SEQ_ALU_DIV_EN
            is_div_r   <= 1'b0;
            neg_rem_r  <= 1'b0;
            div0_r     <= 1'b0;
`endif
        end else if (start) begin
            busy_r     <= 1'b1;
            cnt_r      <= {NB_CNT{1'b0}};
            hi_r       <= ZERO;
            lo_r       <= mag_a_s;
            opb_r      <= mag_b_s;
            neg_prod_r <= neg_a_s ^ neg_b_s;
`ifdef SEQ_ALU_DIV_EN
            is_div_r   <= is_div;
            neg_rem_r  <= neg_a_s;
            div0_r     <= (op_b == ZERO);
`endif
        end else if (busy_r) begin
            hi_r   <= step_hi_s;
            lo_r   <= step_lo_s;
            cnt_r  <= cnt_r + NB_CNT'(1);
            busy_r <= (cnt_r != LAST_CNT);
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU top: valid/ready handshake, single-cycle datapath, control
// FSM and output registers. Multiply/divide run in mdu_core.
// Macro SEQ_ALU_DIV_EN enables the iterative divider; without it DIV/DIVU
// complete in one cycle returning all ones and leave o_hi/o_lo untouched.
module seq_alu
    import alu_pkg::*;
#(
    parameter int NB_DATA      = 32,
    parameter int NB_OPERATION = 4
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic                    i_valid,
    input  logic [NB_DATA-1:0]      i_data_a,
    input  logic [NB_DATA-1:0]      i_data_b,
    input  logic [NB_OPERATION-1:0] i_op,
    output logic                    o_ready,
    output logic                    o_valid,
    output logic [NB_DATA-1:0]      o_result,
    output logic [NB_DATA-1:0]      o_hi,
    output logic [NB_DATA-1:0]      o_lo
);

    localparam int NB_SHAMT = $clog2(NB_DATA);
    localparam logic [NB_DATA-1:0] ZERO = {NB_DATA{1'b0}};
    localparam logic [NB_DATA-1:0] ONES = {NB_DATA{1'b1}};

    state_e               state_r;
    op_e                  op_s;
    logic                 accept_s;
    logic                 is_mul_s;
    logic                 is_div_s;
    logic                 signed_s;
    logic                 start_s;
    logic [NB_SHAMT-1:0]  shamt_s;
    logic [NB_DATA-1:0]   alu_result_s;
    logic                 mdu_done_s;
    logic [NB_DATA-1:0]   mdu_hi_s;
    logic [NB_DATA-1:0]   mdu_lo_s;

    assign op_s     = op_e'(i_op[NB_OPCODE-1:0]);
    assign shamt_s  = i_data_a[NB_SHAMT-1:0];
    assign accept_s = i_valid & o_ready;
    assign is_mul_s = (op_s == OP_MULT) || (op_s == OP_MULTU);
`ifdef SEQ_ALU_DIV_EN
    assign is_div_s = (op_s == OP_DIV) || (op_s == OP_DIVU);
`else
    assign is_div_s = 1'b0;
`endif
    assign signed_s = (op_s == OP_MULT) || (op_s == OP_DIV);
    assign start_s  = accept_s & (is_mul_s | is_div_s);

    mdu_core #(
        .NB_DATA (NB_DATA)
    ) u_mdu (
        .clk       (i_clock),
        .rst       (i_reset),
        .start     (start_s),
`ifdef SEQ_ALU_DIV_EN
        .is_div    (is_div_s),
`endif
        .is_signed (signed_s),
        .op_a      (i_data_a),
        .op_b      (i_data_b),
        .done      (mdu_done_s),
        .res_hi    (mdu_hi_s),
        .res_lo    (mdu_lo_s)
    );

    // Single-cycle datapath; DIV/DIVU only reach here when the divider is absent.
    always_comb begin
        alu_result_s = ZERO;
        case (op_s)
            OP_ADD:   alu_result_s = i_data_a + i_data_b;
            OP_SUB:   alu_result_s = i_data_a - i_data_b;
            OP_AND:   alu_result_s = i_data_a & i_data_b;
            OP_OR:    alu_result_s = i_data_a | i_data_b;
            OP_XOR:   alu_result_s = i_data_a ^ i_data_b;
            OP_NOR:   alu_result_s = ~(i_data_a | i_data_b);
            OP_SRL:   alu_result_s = i_data_b >> shamt_s;
            OP_SLL:   alu_result_s = i_data_b << shamt_s;
            OP_SRA:   alu_result_s = $signed(i_data_b) >>> shamt_s;
            OP_SLA:   alu_result_s = $signed(i_data_b) <<< shamt_s;
            OP_SLT:   alu_result_s = {{(NB_DATA-1){1'b0}}, (i_data_a < i_data_b)};
            OP_LUI:   alu_result_s = i_data_b << (NB_DATA / 2);
            OP_MULT,
            OP_MULTU: alu_result_s = ZERO;
            OP_DIV,
            OP_DIVU:  alu_result_s = ONES;
            default:  alu_result_s = ZERO;
        endcase
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_r  <= ST_IDLE;
            o_ready  <= 1'b0;
            o_valid  <= 1'b0;
            o_result <= ZERO;
            o_hi     <= ZERO;
            o_lo     <= ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    o_ready <= 1'b1;
                    o_valid <= 1'b0;
                    if (accept_s) begin
                        if (is_mul_s | is_div_s) begin
                            state_r <= is_div_s ? ST_DIV : ST_MUL;
                            o_ready <= 1'b0;
                        end else begin
                            o_result <= alu_result_s;
                            o_valid  <= 1'b1;
                        end
                    end
                end
                ST_MUL,
                ST_DIV: begin
                    o_ready <= 1'b0;
                    o_valid <= 1'b0;
                    if (mdu_done_s) begin
                        state_r  <= ST_DONE;
                        o_hi     <= mdu_hi_s;
                        o_lo     <= mdu_lo_s;
                        o_result <= mdu_lo_s;
                        o_valid  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    o_ready <= 1'b1;
                    o_valid <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    o_ready <= 1'b0;
                    o_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu (NB_DATA=32). Honors SEQ_ALU_DIV_EN.
module tb_seq_alu;

    localparam logic [3:0] T_ADD = 4'b0000, T_SUB = 4'b0001, T_AND = 4'b0010,
                           T_OR  = 4'b0011, T_XOR = 4'b0100, T_NOR = 4'b0101,
                           T_SRL = 4'b0110, T_SLL = 4'b0111, T_SRA = 4'b1000,
                           T_SLA = 4'b1001, T_SLT = 4'b1010, T_LUI = 4'b1011,
                           T_MULT = 4'b1100, T_MULTU = 4'b1101,
                           T_DIV = 4'b1110, T_DIVU = 4'b1111;

    logic        clk = 1'b0;
    logic        rst;
    logic        vld;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic        ready_w;
    logic        valid_w;
    logic [31:0] result_w;
    logic [31:0] hi_w;
    logic [31:0] lo_w;

    int n_checks = 0;
    int n_fail   = 0;
    int pulses;
    int vcyc;
    int rdy_low;
    logic [31:0] cap_hi;
    logic [31:0] cap_lo;
    logic [31:0] cap_res;

    always #5 clk = ~clk;

    seq_alu #(
        .NB_DATA      (32),
        .NB_OPERATION (4)
    ) dut (
        .i_clock  (clk),
        .i_reset  (rst),
        .i_valid  (vld),
        .i_data_a (a),
        .i_data_b (b),
        .i_op     (op),
        .o_ready  (ready_w),
        .o_valid  (valid_w),
        .o_result (result_w),
        .o_hi     (hi_w),
        .o_lo     (lo_w)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Present one request for a single cycle; returns at the negedge of cycle 1.
    task automatic issue(input logic [3:0] op_v, input logic [31:0] a_v, input logic [31:0] b_v);
        @(negedge clk);
        vld = 1'b1;
        op  = op_v;
        a   = a_v;
        b   = b_v;
        @(negedge clk);
        vld = 1'b0;
    endtask

    task automatic alu_vec(input string tag, input logic [3:0] op_v,
                           input logic [31:0] a_v, input logic [31:0] b_v, input logic [31:0] exp);
        issue(op_v, a_v, b_v);
        check_eq({tag, " result"}, result_w, exp);
        check_eq({tag, " valid"}, {31'd0, valid_w}, 32'd1);
    endtask

    // Run a multi-cycle op, observing 40 cycles; optionally hold an ADD request while busy.
    task automatic run_mdu(input logic [3:0] op_v, input logic [31:0] a_v,
                           input logic [31:0] b_v, input bit inject);
        pulses  = 0;
        vcyc    = 0;
        rdy_low = 0;
        cap_hi  = 32'd0;
        cap_lo  = 32'd0;
        cap_res = 32'd0;
        issue(op_v, a_v, b_v);
        for (int c = 1; c <= 40; c++) begin
            if (c <= 32 && !ready_w) rdy_low++;
            if (valid_w) begin
                pulses++;
                if (vcyc == 0) begin
                    vcyc    = c;
                    cap_hi  = hi_w;
                    cap_lo  = lo_w;
                    cap_res = result_w;
                end
            end
            if (inject && c == 5) begin
                vld = 1'b1;
                op  = T_ADD;
                a   = 32'd1;
                b   = 32'd1;
            end
            if (inject && c == 20) vld = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic check_mdu(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        check_eq({tag, " hi"}, cap_hi, exp_hi);
        check_eq({tag, " lo"}, cap_lo, exp_lo);
        check_eq({tag, " result"}, cap_res, exp_lo);
        check_eq({tag, " valid cycle"}, 32'(vcyc), 32'd33);
        check_eq({tag, " valid pulses"}, 32'(pulses), 32'd1);
        check_eq({tag, " ready low 1-32"}, 32'(rdy_low), 32'd32);
        check_eq({tag, " ready after"}, {31'd0, ready_w}, 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        vld = 1'b0;
        op  = 4'd0;
        a   = 32'd0;
        b   = 32'd0;
        repeat (3) @(negedge clk);
        check_eq("rst result", result_w, 32'd0);
        check_eq("rst hi", hi_w, 32'd0);
        check_eq("rst lo", lo_w, 32'd0);
        check_eq("rst valid", {31'd0, valid_w}, 32'd0);
        check_eq("rst ready", {31'd0, ready_w}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("ready after rst", {31'd0, ready_w}, 32'd1);

        // Single-cycle operations
        alu_vec("ADD wrap", T_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000);
        @(negedge clk);
        check_eq("ADD valid one cycle", {31'd0, valid_w}, 32'd0);
        alu_vec("SUB", T_SUB, 32'd5, 32'd7, 32'hFFFF_FFFE);
        alu_vec("AND", T_AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0);
        alu_vec("OR",  T_OR,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0);
        alu_vec("XOR", T_XOR, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00);
        alu_vec("NOR", T_NOR, 32'hF0F0_F0F0, 32'h0F0F_0000, 32'h0000_0F0F);
        alu_vec("SRL", T_SRL, 32'd4, 32'h8000_0000, 32'h0800_0000);
        alu_vec("SLL", T_SLL, 32'd8, 32'h0000_00FF, 32'h0000_FF00);
        alu_vec("SLL shamt low bits", T_SLL, 32'h0000_0024, 32'h0000_0001, 32'h0000_0010);
        alu_vec("SRA neg", T_SRA, 32'd4, 32'h8000_0000, 32'hF800_0000);
        alu_vec("SRA pos", T_SRA, 32'd4, 32'h7000_0000, 32'h0700_0000);
        alu_vec("SLA", T_SLA, 32'd1, 32'h4000_0001, 32'h8000_0002);
        alu_vec("SLT unsigned lt", T_SLT, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001);
        alu_vec("SLT unsigned ge", T_SLT, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000);
        alu_vec("LUI", T_LUI, 32'd0, 32'hABCD_1234, 32'h1234_0000);
        check_eq("hi untouched by ALU ops", hi_w, 32'd0);
        check_eq("lo untouched by ALU ops", lo_w, 32'd0);

        // Multiply
        run_mdu(T_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0);
        check_mdu("MULT -2*3", 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        alu_vec("ADD after MULT", T_ADD, 32'd2, 32'd3, 32'd5);
        check_eq("hi kept after ADD", hi_w, 32'hFFFF_FFFF);
        check_eq("lo kept after ADD", lo_w, 32'hFFFF_FFFA);
        run_mdu(T_MULTU, 32'h0001_0000, 32'h0003_0001, 1'b1);
        check_mdu("MULTU busy-ignore", 32'h0000_0003, 32'h0001_0000);
        run_mdu(T_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        check_mdu("MULTU max", 32'hFFFF_FFFE, 32'h0000_0001);
        run_mdu(T_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        check_mdu("MULT -1*-1", 32'h0000_0000, 32'h0000_0001);

`ifdef SEQ_ALU_DIV_EN
        run_mdu(T_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
        check_mdu("DIV -7/2", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_mdu(T_DIVU, 32'd5, 32'd0, 1'b0);
        check_mdu("DIVU 5/0", 32'h0000_0005, 32'hFFFF_FFFF);
        run_mdu(T_DIV, 32'hFFFF_FFF9, 32'd0, 1'b0);
        check_mdu("DIV -7/0", 32'hFFFF_FFF9, 32'hFFFF_FFFF);
        run_mdu(T_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        check_mdu("DIV min/-1", 32'h0000_0000, 32'h8000_0000);
        run_mdu(T_DIVU, 32'd100, 32'd7, 1'b0);
        check_mdu("DIVU 100/7", 32'h0000_0002, 32'h0000_000E);
`else
        alu_vec("DIV no divider", T_DIV, 32'd7, 32'd2, 32'hFFFF_FFFF);
        check_eq("DIV hi kept", hi_w, 32'h0000_0000);
        check_eq("DIV lo kept", lo_w, 32'h0000_0001);
        alu_vec("DIVU no divider", T_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF);
`endif

        // Reset in the middle of a multi-cycle operation
        pulses = 0;
`ifdef SEQ_ALU_DIV_EN
        issue(T_DIVU, 32'd1000, 32'd3);
`else
        issue(T_MULTU, 32'h0000_1234, 32'h0000_5678);
`endif
        for (int c = 1; c < 10; c++) begin
            if (valid_w) pulses++;
            @(negedge clk);
        end
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (valid_w) pulses++;
        end
        check_eq("abort hi", hi_w, 32'd0);
        check_eq("abort lo", lo_w, 32'd0);
        check_eq("abort result", result_w, 32'd0);
        check_eq("abort ready in rst", {31'd0, ready_w}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("abort ready after", {31'd0, ready_w}, 32'd1);
        for (int c = 0; c < 40; c++) begin
            if (valid_w) pulses++;
            @(negedge clk);
        end
        check_eq("abort no valid", 32'(pulses), 32'd0);
        check_eq("abort hi stays", hi_w, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
